// File: rtl/synaptic_accumulator_matrix_pkg.sv
// Shared types and helpers for the synaptic accumulator matrix.
//   state_e  : frame sequencer states
//   sat_add  : signed add with clamp to an acc_w-bit two's-complement range,
//              evaluated at SAT_W bits so any ACC_W below SAT_W-1 fits
//   *_DEF    : default geometry (4 neurons, 8b weights, 12b currents)
package izh_matrix_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam int N_DEF     = 4;
  localparam int W_DEF     = 8;
  localparam int ACC_W_DEF = 12;
  localparam int SAT_W     = 64;

  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] acc,
    input logic signed [SAT_W-1:0] w,
    input int unsigned             acc_w
  );
    logic signed [SAT_W-1:0] sum, hi, lo;
    sum = acc + w;
    hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (acc_w - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

endpackage

// File: rtl/synaptic_accumulator_matrix_if.sv
// Frame control, weight write port and current output of the accumulator.
//   master : start, spikes, wr_en, wr_pre, wr_post, wr_data -> ; <- busy, done, current_out
//   slave  : the mirror image, used by the accumulator itself
interface synaptic_accumulator_matrix_if
  import izh_matrix_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int ACC_W = ACC_W_DEF
);
  localparam int IDX_W = $clog2(N);

  logic                    start;
  logic [N-1:0]            spikes;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_pre;
  logic [IDX_W-1:0]        wr_post;
  logic signed [W-1:0]     wr_data;
  logic                    busy;
  logic                    done;
  logic [N*ACC_W-1:0]      current_out;

  modport master (
    output start, spikes, wr_en, wr_pre, wr_post, wr_data,
    input  busy, done, current_out
  );

  modport slave (
    input  start, spikes, wr_en, wr_pre, wr_post, wr_data,
    output busy, done, current_out
  );
endinterface

// File: rtl/synaptic_accumulator_matrix_sat_accumulator.sv
// One postsynaptic channel: signed accumulator with saturating add.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the accumulator (wins over en)
//   en         : add sign-extended w, clamped to the ACC_W range
//   w          : signed weight; acc : current accumulator value
module sat_accumulator
  import izh_matrix_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [W-1:0]     w,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear)
      acc_d = '0;
    else if (en)
      acc_d = ACC_W'(sat_add({{(SAT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q},
                             {{(SAT_W-W){w[W-1]}}, w}, ACC_W));
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

// File: rtl/synaptic_accumulator_matrix.sv
// N-channel synaptic current aggregator. A start latches the spike vector,
// then one presynaptic row is scanned per cycle and its weights are added
// into every postsynaptic channel; the result is published with a done pulse.
//   clk, reset : clock, synchronous active-high reset (also clears weights)
//   bus        : slave side of synaptic_accumulator_matrix_if
module synaptic_accumulator_matrix
  import izh_matrix_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int W          = W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter bit ALLOW_SELF = 1'b0
) (
  input logic                           clk,
  input logic                           reset,
  synaptic_accumulator_matrix_if.slave  bus
);
  localparam int IDX_W = $clog2(N);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    row_q, row_d;
  logic [N-1:0]        spk_q, spk_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [N*ACC_W-1:0]  cur_q, cur_d;
  // Flat registers: a whole row is read in parallel every SCAN cycle.
  logic signed [W-1:0] weight_q [N][N];
  logic signed [W-1:0] weight_d [N][N];

  logic                acc_clr;
  logic [N-1:0]        acc_en;
  logic [N*ACC_W-1:0]  acc_flat;

  // Writes land at the edge; the scan reads weight_q, so a same-cycle read
  // of the written row still sees the old value.
  always_comb begin
    weight_d = weight_q;
    if (bus.wr_en && (32'(bus.wr_pre) < N) && (32'(bus.wr_post) < N))
      weight_d[bus.wr_pre][bus.wr_post] = bus.wr_data;
  end

  always_comb begin
    acc_en = '0;
    for (int j = 0; j < N; j++)
      acc_en[j] = (state_q == SCAN) && spk_q[row_q] &&
                  (ALLOW_SELF || (32'(row_q) != 32'(j)));
  end

  for (genvar j = 0; j < N; j++) begin : g_ch
    sat_accumulator #(.W(W), .ACC_W(ACC_W)) u_acc (
      .clk   (clk),
      .reset (reset),
      .clear (acc_clr),
      .en    (acc_en[j]),
      .w     (weight_q[row_q][j]),
      .acc   (acc_flat[j*ACC_W +: ACC_W])
    );
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    spk_d   = spk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cur_d   = cur_q;
    acc_clr = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SCAN;
        spk_d   = bus.spikes;
        row_d   = '0;
        busy_d  = 1'b1;
        acc_clr = 1'b1;
      end
      SCAN: begin
        row_d = row_q + 1'b1;
        if (32'(row_q) == N - 1) begin
          state_d = DONE;
          row_d   = '0;
        end
      end
      DONE: begin
        cur_d   = acc_flat;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      spk_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cur_q   <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          weight_q[i][j] <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      spk_q    <= spk_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cur_q    <= cur_d;
      weight_q <= weight_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.current_out = cur_q;
endmodule

// File: tb/tb_synaptic_accumulator_matrix.sv
// Drives two accumulator instances with identical stimulus:
//   u_dut0 : N=4, W=8, ACC_W=12, diagonal skipped
//   u_dut1 : N=4, W=8, ACC_W=8,  diagonal included (saturates readily)
// and compares them against a row-sum reference model.
module tb_synaptic_accumulator_matrix;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int AW0 = 12;
  localparam int AW1 = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                start;
  logic [N-1:0]        spikes;
  logic                wr_en;
  logic [1:0]          wr_pre, wr_post;
  logic signed [W-1:0] wr_data;

  synaptic_accumulator_matrix_if #(.N(N), .W(W), .ACC_W(AW0)) bus0 ();
  synaptic_accumulator_matrix_if #(.N(N), .W(W), .ACC_W(AW1)) bus1 ();

  assign bus0.start = start;   assign bus1.start = start;
  assign bus0.spikes = spikes; assign bus1.spikes = spikes;
  assign bus0.wr_en = wr_en;   assign bus1.wr_en = wr_en;
  assign bus0.wr_pre = wr_pre; assign bus1.wr_pre = wr_pre;
  assign bus0.wr_post = wr_post; assign bus1.wr_post = wr_post;
  assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data;

  synaptic_accumulator_matrix #(.N(N), .W(W), .ACC_W(AW0), .ALLOW_SELF(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  synaptic_accumulator_matrix #(.N(N), .W(W), .ACC_W(AW1), .ALLOW_SELF(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  int checks = 0;
  int errors = 0;
  int wm [N][N];

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum the weights of every fired row, clamping after each add.
  function automatic int model(input int spk, input int aw, input bit self, input int post);
    int hi, lo, acc;
    hi  = (1 << (aw - 1)) - 1;
    lo  = -(1 << (aw - 1));
    acc = 0;
    for (int r = 0; r < N; r++) begin
      if (((spk >> r) & 1) == 0) continue;
      if (r == post && !self) continue;
      acc += wm[r][post];
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
    end
    return acc;
  endfunction

  function automatic int ch0(input int j);
    logic signed [AW0-1:0] t;
    t = bus0.current_out[j*AW0 +: AW0];
    return int'(t);
  endfunction

  function automatic int ch1(input int j);
    logic signed [AW1-1:0] t;
    t = bus1.current_out[j*AW1 +: AW1];
    return int'(t);
  endfunction

  task automatic check_out(input string tag, input int spk);
    for (int j = 0; j < N; j++) begin
      chk($sformatf("%s d0 ch%0d", tag, j), ch0(j), model(spk, AW0, 1'b0, j));
      chk($sformatf("%s d1 ch%0d", tag, j), ch1(j), model(spk, AW1, 1'b1, j));
    end
  endtask

  task automatic wr(input int pre, input int post, input int val);
    @(negedge clk);
    wr_en = 1'b1; wr_pre = pre[1:0]; wr_post = post[1:0]; wr_data = val[W-1:0];
    @(negedge clk);
    wr_en = 1'b0;
    wm[pre][post] = val;
  endtask

  // One frame; optionally issues a weight write in the same cycle as start.
  task automatic frame(input int spk, input string tag,
                       input bit do_wr = 1'b0, input int pre = 0, input int post = 0,
                       input int val = 0);
    int lat;
    bit got;
    @(negedge clk);
    start = 1'b1; spikes = spk[N-1:0];
    if (do_wr) begin
      wr_en = 1'b1; wr_pre = pre[1:0]; wr_post = post[1:0]; wr_data = val[W-1:0];
      wm[pre][post] = val;
    end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    spikes = N'($urandom);  // must not disturb the latched vector
    chk({tag, " busy"}, bus0.busy, 1);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus0.done) got = 1'b1;
    end
    chk({tag, " latency"}, lat, N + 1);
    chk({tag, " done1"}, bus1.done, 1);
    chk({tag, " busy@done"}, bus0.busy, 0);
    check_out(tag, spk);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, bus0.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int nd, since, s_next, s_acc, dn;
    bit pend;
    longint last0, last1;

    reset = 1'b1; start = 1'b0; spikes = '0; wr_en = 1'b0;
    wr_pre = '0; wr_post = '0; wr_data = '0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst busy", bus0.busy, 0);
    chk("rst done", bus0.done, 0);
    chk("rst cur0", bus0.current_out, 0);
    chk("rst cur1", bus1.current_out, 0);
    dn = 0;
    repeat (5) begin @(posedge clk); #1; dn += int'(bus0.done) + int'(bus1.done); end
    chk("idle no done", dn, 0);
    frame(4'b1111, "zero_w");

    // basic accumulation
    wr(1, 0, 5); wr(2, 0, -3); wr(3, 0, 10);
    frame(4'b1010, "basic");
    chk("basic ch0 const", ch0(0), 15);

    // saturation
    for (int r = 0; r < N; r++) wr(r, 2, 100);
    frame(4'b1011, "sat_pos");
    chk("sat_pos d1 const", ch1(2), 127);
    chk("sat_pos d0 const", ch0(2), 300);
    for (int r = 0; r < N; r++) wr(r, 2, -100);
    frame(4'b1011, "sat_neg");
    chk("sat_neg d1 const", ch1(2), -128);

    // diagonal handling
    for (int r = 0; r < N; r++) wr(r, 2, 0);
    wr(2, 2, 50);
    frame(4'b0100, "self");
    chk("self d0 const", ch0(2), 0);
    chk("self d1 const", ch1(2), 50);

    // write issued together with start, read at row 0
    frame(4'b0001, "wr_start", 1'b1, 0, 1, 7);
    chk("wr_start const", ch0(1), 7);

    // random weights and spikes
    repeat (3) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) wr(i, j, int'($urandom_range(255)) - 128);
      frame(int'($urandom_range(15)), "rand");
    end

    // start held high: one frame per N+2 cycles, output stable in between
    nd = 0; since = 0; pend = 1'b1; s_acc = 0;
    s_next = int'($urandom_range(15));
    last0 = bus0.current_out; last1 = bus1.current_out;
    start = 1'b1;
    for (int c = 0; c < 60 && nd < 3; c++) begin
      @(negedge clk);
      spikes = pend ? s_next[N-1:0] : N'($urandom);
      @(posedge clk); #1;
      if (pend) begin
        s_acc = s_next; pend = 1'b0; since = 0;
        s_next = int'($urandom_range(15));
      end else since++;
      if (bus0.done) begin
        nd++;
        chk("cont period", since, N + 1);
        check_out("cont", s_acc);
        last0 = bus0.current_out; last1 = bus1.current_out;
        pend = 1'b1;
      end else begin
        chk("cont stable0", bus0.current_out, last0);
        chk("cont stable1", bus1.current_out, last1);
      end
    end
    start = 1'b0;
    chk("cont frames", nd, 3);

    // reset during SCAN row 2
    @(negedge clk);
    start = 1'b1; spikes = 4'b1111;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = 0;
    chk("midrst busy", bus0.busy, 0);
    chk("midrst done", bus0.done, 0);
    chk("midrst cur0", bus0.current_out, 0);
    chk("midrst cur1", bus1.current_out, 0);
    dn = 0;
    repeat (8) begin @(posedge clk); #1; dn += int'(bus0.done) + int'(bus1.done); end
    chk("midrst no done", dn, 0);
    frame(4'b1111, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
